// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for a small
// 16-bit instruction set. It drives a separate register/ALU datapath and one
// shared memory port.
// Optional feature: define CU_ILLEGAL_TRAP_EN to halt on undefined opcodes
// and raise illegal_op. Without it, undefined opcodes execute as NOP.
//
// Memory handshake: a request strobe (mem_rd_req / mem_wr_req) rises in the
// cycle after its state is entered. It then stays high, with mem_addr and
// mem_wr_data stable, until the responder answers with mem_rd_valid /
// mem_wr_ack in a cycle where the strobe is already high. The strobe drops in
// the following cycle. Only one request is ever outstanding. A valid or ack
// that arrives while no strobe is high is ignored.

package constants_pkg;
  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1,
    ADD       = 2'd2,
    SUB       = 2'd3
  } ALUOp;
endpackage

module control_unit #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_BITS-1:0]    mem_addr,
  output logic                    mem_rd_req,
  input  logic                    mem_rd_valid,
  input  logic [15:0]             mem_rd_data,
  output logic                    mem_wr_req,
  input  logic                    mem_wr_ack,
  output logic [DATA_BITS-1:0]    mem_wr_data,
  output constants_pkg::ALUOp     op,
  output logic [3:0]              addr_a,
  output logic [3:0]              addr_b,
  output logic [3:0]              addr_r,
  output logic [DATA_BITS-1:0]    data_to_regs,
  input  logic [DATA_BITS-1:0]    data_from_regs,
  output logic [ADDR_BITS-1:0]    pc,
  output logic                    halted,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic                    illegal_op,
`endif
  output logic [2:0]              dbg_state_o
);

  import constants_pkg::*;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_ISSUE  = 3'd3,
    S_SETTLE = 3'd4,
    S_MEMWR  = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_ADD   = 4'h1;
  localparam logic [3:0] OPC_SUB   = 4'h2;
  localparam logic [3:0] OPC_LOADI = 4'h3;
  localparam logic [3:0] OPC_LOAD  = 4'h4;
  localparam logic [3:0] OPC_STORE = 4'h5;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  state_t                 state_q;
  logic [15:0]            ir_q;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic                   rd_req_q, wr_req_q;
  logic [DATA_BITS-1:0]   wr_data_q, to_regs_q;
  ALUOp                   op_q;
  logic [3:0]             addr_a_q, addr_b_q, addr_r_q;
  logic                   halted_q;
  logic                   settle_q;
`ifdef CU_ILLEGAL_TRAP_EN
  logic                   illegal_q;
`endif

  // Instruction fields of the latched word. The register field at [11:8]
  // names rR for ALU ops and rA for LOADI/LOAD/STORE.
  logic [3:0] opc, f_hi, f_mid, f_lo;
  logic [7:0] addr8;
  assign opc   = ir_q[15:12];
  assign f_hi  = ir_q[11:8];
  assign f_mid = ir_q[7:4];
  assign f_lo  = ir_q[3:0];
  assign addr8 = ir_q[7:0];

  // The program counter naturally wraps from all-ones back to zero.
  assign pc_d = pc_q + 1'b1;

  // Sequencer: state and every output are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      pc_q       <= '0;
      mem_addr_q <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      to_regs_q  <= '0;
      op_q       <= REG_READ;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_r_q   <= '0;
      halted_q   <= 1'b0;
      settle_q   <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!rd_req_q) begin
            rd_req_q   <= 1'b1;
            mem_addr_q <= pc_q;
          end else if (mem_rd_valid) begin
            rd_req_q <= 1'b0;
            ir_q     <= mem_rd_data;
            pc_q     <= pc_d;
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opc)
            OPC_NOP: state_q <= S_FETCH;
            OPC_ADD, OPC_SUB: begin
              op_q     <= (opc == OPC_ADD) ? ADD : SUB;
              addr_a_q <= f_mid;
              addr_b_q <= f_lo;
              addr_r_q <= f_hi;
              state_q  <= S_ISSUE;
            end
            OPC_LOADI: begin
              op_q      <= REG_WRITE;
              addr_a_q  <= f_hi;
              to_regs_q <= DATA_BITS'(addr8);
              state_q   <= S_ISSUE;
            end
            OPC_LOAD: begin
              addr_a_q <= f_hi;
              state_q  <= S_MEMRD;
            end
            OPC_STORE: begin
              addr_a_q <= f_hi;
              state_q  <= S_ISSUE;
            end
            OPC_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
              illegal_q <= 1'b1;
              halted_q  <= 1'b1;
              state_q   <= S_HALTED;
`else
              state_q <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMRD: begin
          if (!rd_req_q) begin
            rd_req_q   <= 1'b1;
            mem_addr_q <= ADDR_BITS'(addr8);
          end else if (mem_rd_valid) begin
            rd_req_q  <= 1'b0;
            to_regs_q <= mem_rd_data[DATA_BITS-1:0];
            op_q      <= REG_WRITE;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The op is live for this single cycle only. Back to a read so the
          // datapath never sees a second write.
          op_q     <= REG_READ;
          settle_q <= 1'b0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q) begin
            if (opc == OPC_STORE) begin
              wr_data_q <= data_from_regs;
              state_q   <= S_MEMWR;
            end else begin
              state_q <= S_FETCH;
            end
          end else begin
            settle_q <= 1'b1;
          end
        end
        S_MEMWR: begin
          if (!wr_req_q) begin
            wr_req_q   <= 1'b1;
            mem_addr_q <= ADDR_BITS'(addr8);
          end else if (mem_wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= S_FETCH;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_rd_req   = rd_req_q;
  assign mem_wr_req   = wr_req_q;
  assign mem_wr_data  = wr_data_q;
  assign op           = op_q;
  assign addr_a       = addr_a_q;
  assign addr_b       = addr_b_q;
  assign addr_r       = addr_r_q;
  assign data_to_regs = to_regs_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal_op   = illegal_q;
`endif
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: reset values, LOADI/ADD/NOP/STORE/LOAD
// sequencing, request timing, pc wrap, reset during a fetch, and halt.
module tb_control_unit;
  import constants_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem_addr;
  logic        mem_rd_req;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic        mem_wr_req;
  logic        mem_wr_ack;
  logic [7:0]  mem_wr_data;
  ALUOp        op;
  logic [3:0]  addr_a, addr_b, addr_r;
  logic [7:0]  data_to_regs;
  logic [7:0]  data_from_regs;
  logic [7:0]  pc;
  logic        halted;
`ifdef CU_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_req  = 0;

  control_unit #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .mem_wr_req     (mem_wr_req),
    .mem_wr_ack     (mem_wr_ack),
    .mem_wr_data    (mem_wr_data),
    .op             (op),
    .addr_a         (addr_a),
    .addr_b         (addr_b),
    .addr_r         (addr_r),
    .data_to_regs   (data_to_regs),
    .data_from_regs (data_from_regs),
    .pc             (pc),
    .halted         (halted),
`ifdef CU_ILLEGAL_TRAP_EN
    .illegal_op     (illegal_op),
`endif
    .dbg_state_o    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a read request; records the cycle it was first seen.
  task automatic wait_rd(input string tag);
    int n = 0;
    while (mem_rd_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, mem_rd_req}, 32'd1);
    t_req = cyc;
  endtask

  task automatic wait_wr(input string tag);
    int n = 0;
    while (mem_wr_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, mem_wr_req}, 32'd1);
  endtask

  // Answer the pending read with zero extra wait.
  task automatic rd_respond(input logic [15:0] d);
    mem_rd_data  = d;
    mem_rd_valid = 1'b1;
    step();
    mem_rd_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int guard;
    reset          = 1'b1;
    mem_rd_valid   = 1'b0;
    mem_rd_data    = '0;
    mem_wr_ack     = 1'b0;
    data_from_regs = 8'h7E;
    step();
    step();

    // Reset values
    chk("rst_pc",      32'(pc), 32'h0);
    chk("rst_rd_req",  32'(mem_rd_req), 32'h0);
    chk("rst_wr_req",  32'(mem_wr_req), 32'h0);
    chk("rst_op",      32'(op), 32'(REG_READ));
    chk("rst_addr_a",  32'(addr_a), 32'h0);
    chk("rst_addr_b",  32'(addr_b), 32'h0);
    chk("rst_addr_r",  32'(addr_r), 32'h0);
    chk("rst_to_regs", 32'(data_to_regs), 32'h0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'h0);
    chk("rst_addr",    32'(mem_addr), 32'h0);
    chk("rst_halted",  32'(halted), 32'h0);
`ifdef CU_ILLEGAL_TRAP_EN
    chk("rst_illegal", 32'(illegal_op), 32'h0);
`endif

    // Release reset with a stray valid (HALT word) that must be ignored.
    reset        = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 16'hF000;
    step();
    mem_rd_valid = 1'b0;
    chk("first_fetch_req", 32'(mem_rd_req), 32'h1);
    chk("stray_pc",        32'(pc), 32'h0);
    step();
    chk("stray_halted",    32'(halted), 32'h0);
    chk("stray_req_held",  32'(mem_rd_req), 32'h1);

    // LOADI r1, 0x05 at pc 0
    wait_rd("loadi_req");
    chk("loadi_addr", 32'(mem_addr), 32'h0);
    rd_respond(16'h3105);
    chk("loadi_pc",        32'(pc), 32'h1);
    chk("loadi_rd_drop",   32'(mem_rd_req), 32'h0);
    step();
    chk("loadi_op",        32'(op), 32'(REG_WRITE));
    chk("loadi_addr_a",    32'(addr_a), 32'h1);
    chk("loadi_data",      32'(data_to_regs), 32'h05);
    step();
    chk("loadi_op_after",  32'(op), 32'(REG_READ));

    // ADD r3 = r1 + r2 at pc 1, zero-wait memory: 6 cycles request to request
    wait_rd("add_req");
    chk("add_addr", 32'(mem_addr), 32'h1);
    t0 = t_req;
    rd_respond(16'h1312);
    chk("add_op_before", 32'(op), 32'(REG_READ));
    chk("add_pc",        32'(pc), 32'h2);
    step();
    chk("add_op",        32'(op), 32'(ADD));
    chk("add_addr_a",    32'(addr_a), 32'h1);
    chk("add_addr_b",    32'(addr_b), 32'h2);
    chk("add_addr_r",    32'(addr_r), 32'h3);
    step();
    chk("add_op_after",  32'(op), 32'(REG_READ));
    chk("add_a_held",    32'(addr_a), 32'h1);
    wait_rd("add_next_req");
    chk("add_gap", 32'(t_req - t0), 32'd6);

    // NOP at pc 2: fetch plus two cycles
    t0 = t_req;
    rd_respond(16'h0000);
    chk("nop_pc", 32'(pc), 32'h3);
    wait_rd("nop_next_req");
    chk("nop_gap", 32'(t_req - t0), 32'd3);

    // STORE mem[0x40] = r2 at pc 3, ack after 3 waiting cycles
    chk("store_fetch_addr", 32'(mem_addr), 32'h3);
    rd_respond(16'h5240);
    chk("store_pc", 32'(pc), 32'h4);
    step();
    chk("store_issue_op", 32'(op), 32'(REG_READ));
    chk("store_addr_a",   32'(addr_a), 32'h2);
    wait_wr("store_wr_req");
    chk("store_no_rd", 32'(mem_rd_req), 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("store_hold_req%0d", k),  32'(mem_wr_req), 32'h1);
      chk($sformatf("store_hold_addr%0d", k), 32'(mem_addr), 32'h40);
      chk($sformatf("store_hold_data%0d", k), 32'(mem_wr_data), 32'h7E);
      if (k == 3) mem_wr_ack = 1'b1;
      step();
    end
    mem_wr_ack = 1'b0;
    chk("store_wr_drop", 32'(mem_wr_req), 32'h0);

    // LOAD r2 = mem[0x80] at pc 4; upper word bits are not loaded
    wait_rd("load_fetch_req");
    chk("load_fetch_addr", 32'(mem_addr), 32'h4);
    rd_respond(16'h4280);
    chk("load_pc", 32'(pc), 32'h5);
    wait_rd("load_mem_req");
    chk("load_mem_addr", 32'(mem_addr), 32'h80);
    rd_respond(16'h12A5);
    chk("load_op",      32'(op), 32'(REG_WRITE));
    chk("load_addr_a",  32'(addr_a), 32'h2);
    chk("load_data",    32'(data_to_regs), 32'hA5);
    step();
    chk("load_op_after", 32'(op), 32'(REG_READ));

    // Run NOPs up to pc 0xFF and check the wrap
    wait_rd("nop_run_start");
    guard = 0;
    while (mem_addr !== 8'hFF && guard < 300) begin
      rd_respond(16'h0000);
      wait_rd("nop_run_req");
      guard++;
    end
    chk("wrap_fetch_addr", 32'(mem_addr), 32'hFF);
    rd_respond(16'h0000);
    chk("wrap_pc", 32'(pc), 32'h00);
    wait_rd("wrap_next_req");
    chk("wrap_next_addr", 32'(mem_addr), 32'h00);

    // Undefined opcode 0x7 at pc 0
    rd_respond(16'h7000);
    chk("undef_pc", 32'(pc), 32'h1);
    step();
`ifdef CU_ILLEGAL_TRAP_EN
    chk("undef_halted",  32'(halted), 32'h1);
    chk("undef_illegal", 32'(illegal_op), 32'h1);
    chk("undef_no_rd",   32'(mem_rd_req), 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("undef_illegal_clr", 32'(illegal_op), 32'h0);
    wait_rd("undef_refetch");
`else
    chk("undef_halted", 32'(halted), 32'h0);
    wait_rd("undef_next_req");
    chk("undef_next_addr", 32'(mem_addr), 32'h1);
`endif

    // Reset while a fetch is waiting for valid
    reset = 1'b1;
    step();
    chk("midrst_rd_req", 32'(mem_rd_req), 32'h0);
    chk("midrst_pc",     32'(pc), 32'h0);
    reset = 1'b0;
    wait_rd("midrst_refetch");
    chk("midrst_addr", 32'(mem_addr), 32'h0);

    // HALT: terminal, no further requests
    rd_respond(16'hF000);
    step();
    chk("halt_halted", 32'(halted), 32'h1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("halt_no_rd%0d", k), 32'(mem_rd_req), 32'h0);
      chk($sformatf("halt_no_wr%0d", k), 32'(mem_wr_req), 32'h0);
    end
    chk("halt_still", 32'(halted), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, register/ALU data width.
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, program/data memory address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port mem_addr, output, ADDR_BITS, memory address for fetch, LOAD and STORE.
REQ-006 The block SHALL have port mem_rd_req, output, 1, read request, held until mem_rd_valid.
REQ-007 The block SHALL have port mem_rd_valid, input, 1, read data valid this cycle.
REQ-008 The block SHALL have port mem_rd_data, input, 16, read word; data loads use bits [DATA_BITS-1:0].
REQ-009 The block SHALL have port mem_wr_req, output, 1, write request, held until mem_wr_ack.
REQ-010 The block SHALL have port mem_wr_ack, input, 1, write accepted this cycle.
REQ-011 The block SHALL have port mem_wr_data, output, DATA_BITS, write data.
REQ-012 The block SHALL have port op, output, constants_pkg::ALUOp, operation to the register/ALU datapath.
REQ-013 The block SHALL have ports addr_a, addr_b and addr_r, each output, 4 bits, register selects.
REQ-014 The block SHALL have port data_to_regs, output, DATA_BITS, value written by REG_WRITE.
REQ-015 The block SHALL have port data_from_regs, input, DATA_BITS, datapath read port (rA).
REQ-016 The block SHALL have ports pc, output, ADDR_BITS, current program counter, and halted, output, 1, high in HALTED.

Function
REQ-017 Instruction format SHALL be [15:12] opcode, [11:8] rR, [7:4] rA, [3:0] rB; imm8 and addr8 SHALL be [7:0], with rA taken from [11:8] for LOADI, LOAD and STORE.
REQ-018 Opcodes SHALL be: 0x0 NOP; 0x1 ADD rR=rA+rB; 0x2 SUB rR=rA-rB; 0x3 LOADI rA=imm8; 0x4 LOAD rA=mem[addr8]; 0x5 STORE mem[addr8]=rA; 0xF HALT; all others undefined.
REQ-019 States SHALL be FETCH, DECODE, MEMRD, ISSUE, SETTLE, MEMWR and HALTED.
REQ-020 FETCH SHALL assert mem_rd_req with mem_addr=pc until mem_rd_valid, latch the word, increment pc (wrapping 2^ADDR_BITS-1 to 0) and go to DECODE.
REQ-021 DECODE (1 cycle) SHALL go to ISSUE for ADD/SUB/LOADI/STORE, to MEMRD for LOAD, to FETCH for NOP, and to HALTED for HALT.
REQ-022 MEMRD SHALL assert mem_rd_req with mem_addr=addr8 until mem_rd_valid, latch the data, then go to ISSUE.
REQ-023 ISSUE SHALL drive op for exactly one cycle: ADD/SUB with addr_a=rA, addr_b=rB, addr_r=rR; REG_WRITE with addr_a=rA and data_to_regs=imm8 or the latched load data; REG_READ with addr_a=rA for STORE.
REQ-024 Outside ISSUE, op SHALL be REG_READ with addr_a holding the last decoded rA, so the datapath performs no write.
REQ-025 SETTLE SHALL last 2 cycles, then go to MEMWR for STORE (capturing data_from_regs on its last cycle) or to FETCH otherwise.
REQ-026 MEMWR SHALL hold mem_wr_req, mem_addr=addr8 and mem_wr_data until mem_wr_ack, then go to FETCH.
REQ-027 HALTED SHALL be terminal until reset, with halted=1 and no memory requests.
REQ-028 Request strobes SHALL deassert in the cycle after the valid/ack cycle, and at most one memory request SHALL be outstanding.
REQ-029 An ack or valid arriving while no request is pending SHALL be ignored.
REQ-030 A NOP SHALL take fetch latency+2 cycles and an ADD with zero-wait memory SHALL take 6 cycles from request to the next request.

Reset
REQ-031 On reset the block SHALL set state=FETCH, pc=0, mem_rd_req=0, mem_wr_req=0, op=REG_READ, addr_a/b/r=0, data_to_regs=0, mem_wr_data=0, mem_addr=0 and halted=0.
REQ-032 Reset mid-transaction SHALL drop any pending request in the next cycle without waiting for valid/ack, and the first FETCH SHALL begin on the cycle after reset deasserts.

Configuration
REQ-033 With CU_ILLEGAL_TRAP_EN defined, an undefined opcode SHALL enter HALTED and set output illegal_op=1 (reset 0).
REQ-034 Without CU_ILLEGAL_TRAP_EN, an undefined opcode SHALL execute as NOP, and port illegal_op SHALL not exist.

Verification
REQ-035 Fetching 0x3105 at pc 0 SHALL produce one ISSUE cycle with op=REG_WRITE, addr_a=1, data_to_regs=0x05, followed by pc=1.
REQ-036 Fetching 0x1312 (ADD) SHALL produce one ISSUE cycle with op=ADD, addr_a=1, addr_b=2, addr_r=3, and op=REG_READ in the cycles before and after it.
REQ-037 Executing STORE 0x5240 with data_from_regs=0x7E and mem_wr_ack delayed 3 cycles SHALL hold mem_wr_req=1, mem_addr=0x40, mem_wr_data=0x7E for 4 cycles, then deassert.
REQ-038 Fetching from pc=0xFF SHALL wrap pc to 0x00, and the next fetch SHALL use mem_addr=0x00.
REQ-039 Asserting reset while mem_rd_req is waiting for valid SHALL give mem_rd_req=0 and pc=0 on the next cycle, and a new fetch at address 0.
REQ-040 Executing 0xF000 SHALL set halted=1 with no further requests for 20 cycles; executing 0x7000 SHALL halt with illegal_op=1 when CU_ILLEGAL_TRAP_EN is defined and otherwise advance pc.
